tx_module: RTL and testbench

//   Serial UART-style transmitter; one clock domain.

---
 rtl/tx_module.sv | 189 ++++++++++++++++++
 tb/tb_tx_module.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tx_module.sv
// UART-style serial transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Optional parity bit is enabled by defining TX_PARITY_EN.
module tx_module #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy
);

    // state  | meaning
    // IDLE   | line idle high, waiting for enable
    // START  | start bit (0) on the line
    // DATA   | data bits, shift_q[0] on the line, LSB first
    // PARITY | even parity of the latched word (TX_PARITY_EN only)
    // STOP   | stop bit (1); chains into START if enable is still high
`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
`ifdef TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic            bit_done;

    assign bit_done = (clk_cnt_q == CLK_LAST);
    assign tx       = tx_q;
    assign busy     = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

`ifdef TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // tx_d always carries the level of the bit being entered, so tx is a clean flop output.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (enable) begin
                    state_d   = START;
                    shift_d   = data_in;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
`ifdef TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                end
            end

            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d   = STOP;
                    clk_cnt_d = '0;
                    tx_d      = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
`endif

            STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    if (enable) begin
                        state_d  = START;
                        shift_d  = data_in;
                        tx_d     = 1'b0;
                        busy_d   = 1'b1;
`ifdef TX_PARITY_EN
                        parity_d = ^data_in;
`endif
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_module.sv
// Directed self-checking bench for tx_module: one instance at 1 clk/bit, one at 4 clks/bit.
module tb_tx_module;

`ifdef TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       reset;
    logic       en1, en4;
    logic [7:0] d1, d4;
    logic       tx1, tx4, busy1, busy4;

    int total;
    int bad;

    tx_module #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .enable(en1), .data_in(d1), .tx(tx1), .busy(busy1)
    );

    tx_module #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .enable(en4), .data_in(d4), .tx(tx4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the start bit was launched; returns one negedge past the stop bit.
    task automatic check_frame(input bit sel4, input logic [7:0] d, input int cpb, input string tag);
        logic [10:0] f;
        f = frame_bits(d);
        for (int i = 0; i < NB * cpb; i++) begin
            check($sformatf("%s_tx[%0d]", tag, i), sel4 ? tx4 : tx1, f[i / cpb]);
            check($sformatf("%s_busy[%0d]", tag, i), sel4 ? busy4 : busy1, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        en1 = 1'b0; en4 = 1'b0;
        d1  = 8'h00; d4 = 8'h00;

        // reset held: outputs stay idle while clock runs, even with enable high
        en1 = 1'b1; d1 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_tx1", tx1, 1'b1);
            check("rst_busy1", busy1, 1'b0);
            check("rst_tx4", tx4, 1'b1);
            check("rst_busy4", busy4, 1'b0);
        end
        en1 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_tx1", tx1, 1'b1);
        check("idle_busy1", busy1, 1'b0);

        // 0x55 pulsed enable at 1 clk/bit
        d1 = 8'h55; en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        check("h55_start_const", tx1, 1'b0);
        check_frame(1'b0, 8'h55, 1, "h55");
        check("h55_idle_tx", tx1, 1'b1);
        check("h55_idle_busy", busy1, 1'b0);
        @(negedge clk);
        check("h55_idle2_tx", tx1, 1'b1);

        // 0x01 frame: parity bit 1 when enabled
        d1 = 8'h01; en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        check_frame(1'b0, 8'h01, 1, "h01");
        check("h01_idle_busy", busy1, 1'b0);

        // back-to-back frames, enable held high through the first stop bit
        d1 = 8'hA5; en1 = 1'b1;
        @(negedge clk);
        d1 = 8'h3C;
        check_frame(1'b0, 8'hA5, 1, "hA5");
        en1 = 1'b0;
        check("b2b_start", tx1, 1'b0);
        check_frame(1'b0, 8'h3C, 1, "h3C");
        check("b2b_idle_tx", tx1, 1'b1);
        check("b2b_idle_busy", busy1, 1'b0);

        // data_in and enable change mid-frame; latched word must go out intact
        d1 = 8'h96; en1 = 1'b1;
        @(negedge clk);
        fork
            check_frame(1'b0, 8'h96, 1, "h96");
            begin
                repeat (3) @(negedge clk);
                d1  = 8'h00;
                en1 = 1'b0;
            end
        join
        check("h96_idle_tx", tx1, 1'b1);
        check("h96_idle_busy", busy1, 1'b0);

        // 0xFF at 4 clks/bit
        d4 = 8'hFF; en4 = 1'b1;
        @(negedge clk);
        en4 = 1'b0;
        check_frame(1'b1, 8'hFF, 4, "hFF");
        check("hFF_idle_tx", tx4, 1'b1);
        check("hFF_idle_busy", busy4, 1'b0);

        // asynchronous reset in the middle of a frame
        d4 = 8'h00; en4 = 1'b1;
        @(negedge clk);
        en4 = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_tx4", tx4, 1'b0);
        check("pre_rst_busy4", busy4, 1'b1);
        reset = 1'b0;
        #1;
        check("async_rst_tx4", tx4, 1'b1);
        check("async_rst_busy4", busy4, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_tx4", tx4, 1'b1);
        check("post_rst_busy4", busy4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
